// File: rtl/tdm_demux_1x4_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int unsigned NSLOT = 4;

  typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_demux_1x4_if.sv
// Lane/channel bundle for tdm_demux_1x4. Parity signals exist only when
// TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux_1x4_if #(
  parameter int unsigned W = 1
);
  import tdm_demux_pkg::*;

  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic         frame_vld;
  slot_t        sel;
  logic         locked;
  logic         sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic         din_par;
  logic         par_err;
`endif

  // Demux side
  modport slave (
    input  din, din_valid, sync,
`ifdef TDM_DEMUX_PARITY_EN
    input  din_par,
    output par_err,
`endif
    output y0, y1, y2, y3, frame_vld, sel, locked, sync_err
  );

  // Lane driver / observer side
  modport master (
    output din, din_valid, sync,
`ifdef TDM_DEMUX_PARITY_EN
    output din_par,
    input  par_err,
`endif
    input  y0, y1, y2, y3, frame_vld, sel, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux_1x4_slot_fsm.sv
// Framing FSM: HUNT/LOCK state, slot counter, sync_err pulse. Emits the
// shadow write enables and the frame-commit strobe for the datapath.
module tdm_slot_fsm
  import tdm_demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic       sync_i,
  output slot_t      sel_o,
  output logic       locked_o,
  output logic       sync_err_o,
  output logic [2:0] sh_we_o,
  output logic       commit_o
);

  state_e state_q, state_d;
  slot_t  sel_q, sel_d;
  logic   err_q, err_d;

  // State, slot counter and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // Next-state, slot advance, shadow write enables and commit strobe
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    sh_we_o  = '0;
    commit_o = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (sync_i) begin
            sh_we_o[0] = 1'b1;
            sel_d      = 2'd1;
            state_d    = LOCK;
          end
        end
        LOCK: begin
          if (sync_i && (sel_q != 2'd0)) begin
            // Early sync restarts the frame with this word as slot 0
            err_d      = 1'b1;
            sh_we_o[0] = 1'b1;
            sel_d      = 2'd1;
          end else if (!sync_i && (sel_q == 2'd0)) begin
            err_d   = 1'b1;
            sel_d   = 2'd0;
            state_d = HUNT;
          end else begin
            unique case (sel_q)
              2'd0: sh_we_o[0] = 1'b1;
              2'd1: sh_we_o[1] = 1'b1;
              2'd2: sh_we_o[2] = 1'b1;
              2'd3: commit_o   = 1'b1;
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign sel_o      = sel_q;
  assign locked_o   = (state_q == LOCK);
  assign sync_err_o = err_q;

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: assembles four slot words into a coherent frame.
// Optional even-parity checking via TDM_DEMUX_PARITY_EN.
module tdm_demux_1x4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tdm_demux_1x4_if.slave   bus
);

  logic [2:0]   sh_we;
  logic         commit;
  logic         frame_ok;
  logic [W-1:0] sh_q [3];
  logic [W-1:0] y_q  [NSLOT];
  logic         fv_q;

  tdm_slot_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (bus.din_valid),
    .sync_i     (bus.sync),
    .sel_o      (bus.sel),
    .locked_o   (bus.locked),
    .sync_err_o (bus.sync_err),
    .sh_we_o    (sh_we),
    .commit_o   (commit)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic perr;
  logic bad_q, bad_d;
  logic perr_q;

  assign perr = bus.din_valid & (^{bus.din, bus.din_par});

  // Bad-frame flag restarts at each slot 0 and accumulates through slot 2
  always_comb begin
    bad_d = bad_q;
    if (sh_we[0])
      bad_d = perr;
    else if (|sh_we[2:1])
      bad_d = bad_q | perr;
  end

  // Parity flag and error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      bad_q  <= bad_d;
      perr_q <= perr;
    end
  end

  assign frame_ok    = commit & ~(bad_q | perr);
  assign bus.par_err = perr_q;
`else
  assign frame_ok = commit;
`endif

  // Shadow slots, output frame and frame_vld pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) sh_q[i] <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) y_q[i] <= '0;
      fv_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++)
        if (sh_we[i]) sh_q[i] <= bus.din;
      if (frame_ok) begin
        y_q[0] <= sh_q[0];
        y_q[1] <= sh_q[1];
        y_q[2] <= sh_q[2];
        y_q[3] <= bus.din;
      end
      fv_q <= frame_ok;
    end
  end

  assign bus.y0        = y_q[0];
  assign bus.y1        = y_q[1];
  assign bus.y2        = y_q[2];
  assign bus.y3        = y_q[3];
  assign bus.frame_vld = fv_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed self-checking bench for tdm_demux_1x4 (W=4).
module tb_tdm_demux_1x4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  tdm_demux_1x4_if #(.W(4)) bus ();

  tdm_demux_1x4 #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, then sample 1 time unit after the rising edge
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    bus.din_valid = v;
    bus.sync      = s;
    bus.din       = d;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par   = ^d;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.din_valid = 1'b0; bus.sync = 1'b0; bus.din = '0;
`ifdef TDM_DEMUX_PARITY_EN
    bus.din_par = 1'b0;
`endif
    rst_n = 1'b0;
    #12;
    tests++; if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h0000) begin fails++; $display("FAIL reset_y got=%h exp=0000", {bus.y0, bus.y1, bus.y2, bus.y3}); end
    tests++; if ({bus.frame_vld, bus.sync_err, bus.locked, bus.sel} !== 5'b0) begin fails++; $display("FAIL reset_ctl got=%b exp=00000", {bus.frame_vld, bus.sync_err, bus.locked, bus.sel}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_frame();
    step(1, 1, 4'hA);
    tests++; if ({bus.locked, bus.sel} !== 3'b101) begin fails++; $display("FAIL clean_lock got=%b exp=101", {bus.locked, bus.sel}); end
    step(1, 0, 4'h5);
    step(1, 0, 4'hC);
    tests++; if ({bus.sel, bus.frame_vld} !== 3'b110) begin fails++; $display("FAIL clean_slot3 got=%b exp=110", {bus.sel, bus.frame_vld}); end
    step(1, 0, 4'h3);
    tests++; if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'hA5C3) begin fails++; $display("FAIL clean_y got=%h exp=a5c3", {bus.y0, bus.y1, bus.y2, bus.y3}); end
    tests++; if ({bus.frame_vld, bus.locked, bus.sel} !== 4'b1100) begin fails++; $display("FAIL clean_ctl got=%b exp=1100", {bus.frame_vld, bus.locked, bus.sel}); end
    step(0, 0, 4'h0);
    tests++; if (bus.frame_vld !== 1'b0) begin fails++; $display("FAIL clean_pulse got=%b exp=0", bus.frame_vld); end
  endtask

  task automatic test_stall();
    int pulses = 0;
    step(1, 1, 4'hA); pulses += int'(bus.frame_vld);
    step(1, 0, 4'h5); pulses += int'(bus.frame_vld);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'hF); pulses += int'(bus.frame_vld);
      tests++; if ({bus.sel, bus.sync_err} !== 3'b100) begin fails++; $display("FAIL stall_sel%0d got=%b exp=100", i, {bus.sel, bus.sync_err}); end
    end
    step(1, 0, 4'hC); pulses += int'(bus.frame_vld);
    tests++; if (pulses !== 0) begin fails++; $display("FAIL stall_early_vld got=%0d exp=0", pulses); end
    step(1, 0, 4'h3);
    tests++; if ({bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3} !== 17'h1A5C3) begin fails++; $display("FAIL stall_frame got=%h exp=1a5c3", {bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3}); end
  endtask

  task automatic test_early_sync();
    step(1, 1, 4'h1);
    step(1, 0, 4'h2);
    step(1, 1, 4'h7);
    tests++; if ({bus.sync_err, bus.locked, bus.sel} !== 4'b1101) begin fails++; $display("FAIL early_err got=%b exp=1101", {bus.sync_err, bus.locked, bus.sel}); end
    step(1, 0, 4'h8);
    tests++; if (bus.sync_err !== 1'b0) begin fails++; $display("FAIL early_pulse got=%b exp=0", bus.sync_err); end
    step(1, 0, 4'h9);
    tests++; if ({bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3} !== 17'h0A5C3) begin fails++; $display("FAIL early_hold got=%h exp=0a5c3", {bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3}); end
    step(1, 0, 4'hA);
    tests++; if ({bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3} !== 17'h1789A) begin fails++; $display("FAIL early_frame got=%h exp=1789a", {bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3}); end
  endtask

  task automatic test_missing_sync();
    int pulses = 0;
    step(1, 0, 4'h4);
    tests++; if ({bus.sync_err, bus.locked, bus.sel} !== 4'b1000) begin fails++; $display("FAIL miss_err got=%b exp=1000", {bus.sync_err, bus.locked, bus.sel}); end
    tests++; if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h789A) begin fails++; $display("FAIL miss_hold got=%h exp=789a", {bus.y0, bus.y1, bus.y2, bus.y3}); end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'(i + 6));
      pulses += int'(bus.frame_vld) + int'(bus.sync_err) + int'(bus.locked) + int'(bus.sel != 2'd0);
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL miss_ignore got=%0d exp=0", pulses); end
    step(1, 1, 4'hB); step(1, 0, 4'hC); step(1, 0, 4'hD); step(1, 0, 4'hE);
    tests++; if ({bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3} !== 17'h1BCDE) begin fails++; $display("FAIL miss_relock got=%h exp=1bcde", {bus.frame_vld, bus.y0, bus.y1, bus.y2, bus.y3}); end
  endtask

  task automatic test_reset_mid_frame();
    int pulses = 0;
    step(1, 1, 4'h1);
    step(1, 0, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({bus.y0, bus.y1, bus.y2, bus.y3, bus.frame_vld, bus.sync_err, bus.locked, bus.sel} !== 21'h0) begin fails++; $display("FAIL midrst_clear got=%h exp=0", {bus.y0, bus.y1, bus.y2, bus.y3, bus.frame_vld, bus.sync_err, bus.locked, bus.sel}); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 4'hF); pulses += int'(bus.frame_vld);
    step(1, 0, 4'hF); pulses += int'(bus.frame_vld);
    tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL midrst_hunt got=%b exp=0", bus.locked); end
    step(1, 1, 4'h3); pulses += int'(bus.frame_vld);
    step(1, 0, 4'h4); pulses += int'(bus.frame_vld);
    step(1, 0, 4'h5); pulses += int'(bus.frame_vld);
    step(1, 0, 4'h6); pulses += int'(bus.frame_vld);
    step(0, 0, 4'h0); pulses += int'(bus.frame_vld);
    tests++; if (pulses !== 1) begin fails++; $display("FAIL midrst_vld_count got=%0d exp=1", pulses); end
    tests++; if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h3456) begin fails++; $display("FAIL midrst_y got=%h exp=3456", {bus.y0, bus.y1, bus.y2, bus.y3}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vld_seen = '0;
    for (int i = 0; i < 8; i++) begin
      step(1, (i % 4) == 0, 4'(i + 1));
      vld_seen[i] = bus.frame_vld;
    end
    tests++; if (vld_seen !== 8'b1000_1000) begin fails++; $display("FAIL b2b_vld got=%b exp=10001000", vld_seen); end
    tests++; if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 16'h5678) begin fails++; $display("FAIL b2b_y got=%h exp=5678", {bus.y0, bus.y1, bus.y2, bus.y3}); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_stall();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
